// File: rtl/color_freq_scanner.sv
// Colour-sensor frequency scanner: steps the sensor filter through red, green and blue,
// counts colorsignal edges in a fixed gate window per filter, and reports the dominant colour.
module color_freq_scanner #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             colorsignal,
  input  logic             enable,
  output logic             s2,
  output logic             s3,
  output logic [1:0]       top_color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count
);

  localparam int          TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [31:0] MIN_U   = MIN_COUNT;

  localparam logic [1:0] CH_RED     = 2'd0;
  localparam logic [1:0] CH_GREEN   = 2'd1;
  localparam logic [1:0] CH_BLUE    = 2'd2;
  localparam logic [1:0] COLOR_NONE = 2'd3;

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, COMPARE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         chan_q, chan_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]   red_int_q, red_int_d, green_int_q, green_int_d, blue_int_q, blue_int_d;
  logic [CNT_W-1:0]   red_out_q, red_out_d, green_out_q, green_out_d, blue_out_q, blue_out_d;
  logic               s2_q, s2_d, s3_q, s3_d;
  logic [1:0]         top_q, top_d;
  logic               valid_q, valid_d;
  logic               sync1_q, sync2_q, prev_q;
  logic               edge_pulse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // Ties fall to the earlier channel: red beats green beats blue.
  function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] best;
    logic [1:0]       ch;
    if (r >= g && r >= b) begin
      best = r;
      ch   = CH_RED;
    end else if (g >= b) begin
      best = g;
      ch   = CH_GREEN;
    end else begin
      best = b;
      ch   = CH_BLUE;
    end
    if (32'(best) < MIN_U) ch = COLOR_NONE;
    return ch;
  endfunction

  assign edge_pulse = sync2_q & ~prev_q;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    timer_d     = timer_q;
    edge_cnt_d  = edge_cnt_q;
    red_int_d   = red_int_q;
    green_int_d = green_int_q;
    blue_int_d  = blue_int_q;
    red_out_d   = red_out_q;
    green_out_d = green_out_q;
    blue_out_d  = blue_out_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    top_d       = top_q;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        chan_d = CH_RED;
        s2_d   = 1'b0;
        s3_d   = 1'b0;
        if (enable) begin
          state_d = SETTLE;
          timer_d = '0;
        end
      end
      SETTLE: begin
        if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d    = GATE;
          timer_d    = '0;
          edge_cnt_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GATE: begin
        edge_cnt_d = sat_inc(edge_cnt_q, edge_pulse);
        if (timer_q == TMR_W'(GATE_CYCLES - 1)) state_d = STORE;
        else                                     timer_d = timer_q + 1'b1;
      end
      STORE: begin
        timer_d = '0;
        case (chan_q)
          CH_RED: begin
            red_int_d = edge_cnt_q;
            chan_d    = CH_GREEN;
            {s2_d, s3_d} = 2'b11;
            state_d   = SETTLE;
          end
          CH_GREEN: begin
            green_int_d = edge_cnt_q;
            chan_d      = CH_BLUE;
            {s2_d, s3_d} = 2'b01;
            state_d     = SETTLE;
          end
          default: begin
            blue_int_d = edge_cnt_q;
            state_d    = COMPARE;
          end
        endcase
      end
      COMPARE: begin
        top_d       = pick_color(red_int_q, green_int_q, blue_int_q);
        red_out_d   = red_int_q;
        green_out_d = green_int_q;
        blue_out_d  = blue_int_q;
        valid_d     = 1'b1;
        chan_d      = CH_RED;
        {s2_d, s3_d} = 2'b00;
        state_d     = SETTLE;
        timer_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    // Losing enable anywhere mid-frame throws the frame away and leaves the outputs alone.
    if (!enable && state_q != IDLE) begin
      state_d     = IDLE;
      chan_d      = CH_RED;
      timer_d     = '0;
      s2_d        = 1'b0;
      s3_d        = 1'b0;
      red_int_d   = red_int_q;
      green_int_d = green_int_q;
      blue_int_d  = blue_int_q;
      red_out_d   = red_out_q;
      green_out_d = green_out_q;
      blue_out_d  = blue_out_q;
      top_d       = top_q;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      chan_q      <= CH_RED;
      timer_q     <= '0;
      edge_cnt_q  <= '0;
      red_int_q   <= '0;
      green_int_q <= '0;
      blue_int_q  <= '0;
      red_out_q   <= '0;
      green_out_q <= '0;
      blue_out_q  <= '0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      top_q       <= COLOR_NONE;
      valid_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      timer_q     <= timer_d;
      edge_cnt_q  <= edge_cnt_d;
      red_int_q   <= red_int_d;
      green_int_q <= green_int_d;
      blue_int_q  <= blue_int_d;
      red_out_q   <= red_out_d;
      green_out_q <= green_out_d;
      blue_out_q  <= blue_out_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      top_q       <= top_d;
      valid_q     <= valid_d;
      sync1_q     <= colorsignal;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
    end
  end

  assign s2          = s2_q;
  assign s3          = s3_q;
  assign top_color   = top_q;
  assign color_valid = valid_q;
  assign red_count   = red_out_q;
  assign green_count = green_out_q;
  assign blue_count  = blue_out_q;

endmodule

// File: tb/tb_color_freq_scanner.sv
// Directed bench for color_freq_scanner: small-window instance for frame behaviour and
// a 4-bit-count instance with a long gate window for saturation.
module tb_color_freq_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       colorsignal, enable;
  logic       s2, s3, color_valid;
  logic [1:0] top_color;
  logic [7:0] red_count, green_count, blue_count;

  logic       colorsignal2, enable2;
  logic       s2_2, s3_2, color_valid2;
  logic [1:0] top_color2;
  logic [3:0] red_count2, green_count2, blue_count2;

  int passed = 0;
  int total  = 0;

  logic [1:0] prev_top;
  logic [7:0] prev_r, prev_g, prev_b;

  always #5 clk = ~clk;

  color_freq_scanner #(.GATE_CYCLES(20), .SETTLE_CYCLES(4), .CNT_W(8), .MIN_COUNT(3)) dut (
    .clock(clk), .reset(reset), .colorsignal(colorsignal), .enable(enable),
    .s2(s2), .s3(s3), .top_color(top_color), .color_valid(color_valid),
    .red_count(red_count), .green_count(green_count), .blue_count(blue_count)
  );

  color_freq_scanner #(.GATE_CYCLES(64), .SETTLE_CYCLES(4), .CNT_W(4), .MIN_COUNT(3)) dut_sat (
    .clock(clk), .reset(reset), .colorsignal(colorsignal2), .enable(enable2),
    .s2(s2_2), .s3(s3_2), .top_color(top_color2), .color_valid(color_valid2),
    .red_count(red_count2), .green_count(green_count2), .blue_count(blue_count2)
  );

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; colorsignal = 1'b1;
    enable2 = 1'b0; colorsignal2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 colorsignal = 1'b0;
    @(negedge clk);
    total++; if (top_color !== 2'd3) $display("FAIL reset_top: got %0d expected 3", top_color); else passed++;
    total++; if (color_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", color_valid); else passed++;
    total++; if ({s2, s3} !== 2'b00) $display("FAIL reset_s2s3: got %b expected 00", {s2, s3}); else passed++;
    total++; if ({red_count, green_count, blue_count} !== 24'd0)
      $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", red_count, green_count, blue_count);
    else passed++;
    total++; if ({top_color2, red_count2} !== 6'b11_0000)
      $display("FAIL reset_sat: got top %0d red %0d expected 3/0", top_color2, red_count2);
    else passed++;
    prev_top = 2'd3; prev_r = 8'd0; prev_g = 8'd0; prev_b = 8'd0;
  endtask

  // Cycle 0 is the first SETTLE cycle. A pulse started in cycle c becomes an edge pulse in c+2;
  // gates span cycles 4-23 (red), 29-48 (green), 54-73 (blue); color_valid lands in cycle 76.
  task automatic run_frame(input string name, input int nr, input int ng, input int nb,
                           input bit noise, input logic [1:0] etop);
    logic       sig [0:76];
    int         vcount, vcycle;
    logic [1:0] got_top;
    logic [7:0] got_r, got_g, got_b;
    for (int i = 0; i <= 76; i++) sig[i] = 1'b0;
    for (int k = 0; k < nr; k++) sig[2 + 2*k]  = 1'b1;
    for (int k = 0; k < ng; k++) sig[27 + 2*k] = 1'b1;
    for (int k = 0; k < nb; k++) sig[52 + 2*k] = 1'b1;
    if (noise) begin
      sig[0] = 1'b1; sig[23] = 1'b1; sig[25] = 1'b1; sig[48] = 1'b1; sig[50] = 1'b1;
    end
    vcount = 0; vcycle = -1;
    got_top = 2'd0; got_r = 8'd0; got_g = 8'd0; got_b = 8'd0;
    reset = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 76; c++) begin
      colorsignal = sig[c];
      if (c == 76) enable = 1'b0;
      @(negedge clk);
      if (color_valid === 1'b1) begin
        vcount++; vcycle = c;
        got_top = top_color; got_r = red_count; got_g = green_count; got_b = blue_count;
      end
      if (c == 10) begin
        total++; if ({s2, s3} !== 2'b00) $display("FAIL %s s2s3_red: got %b expected 00", name, {s2, s3}); else passed++;
      end
      if (c == 35) begin
        total++; if ({s2, s3} !== 2'b11) $display("FAIL %s s2s3_green: got %b expected 11", name, {s2, s3}); else passed++;
      end
      if (c == 60) begin
        total++; if ({s2, s3} !== 2'b01) $display("FAIL %s s2s3_blue: got %b expected 01", name, {s2, s3}); else passed++;
      end
      if (c == 70) begin
        total++;
        if ({top_color, red_count, green_count, blue_count} !== {prev_top, prev_r, prev_g, prev_b})
          $display("FAIL %s held_outputs: got %0d %0d/%0d/%0d expected %0d %0d/%0d/%0d", name,
                   top_color, red_count, green_count, blue_count, prev_top, prev_r, prev_g, prev_b);
        else passed++;
      end
      @(posedge clk); #1;
    end
    colorsignal = 1'b0;
    @(negedge clk);
    total++; if (vcount != 1) $display("FAIL %s valid_pulses: got %0d expected 1", name, vcount); else passed++;
    total++; if (vcycle != 76) $display("FAIL %s valid_cycle: got %0d expected 76", name, vcycle); else passed++;
    total++; if (got_top !== etop) $display("FAIL %s top_color: got %0d expected %0d", name, got_top, etop); else passed++;
    total++; if (got_r !== 8'(nr)) $display("FAIL %s red_count: got %0d expected %0d", name, got_r, nr); else passed++;
    total++; if (got_g !== 8'(ng)) $display("FAIL %s green_count: got %0d expected %0d", name, got_g, ng); else passed++;
    total++; if (got_b !== 8'(nb)) $display("FAIL %s blue_count: got %0d expected %0d", name, got_b, nb); else passed++;
    total++; if (color_valid !== 1'b0) $display("FAIL %s valid_after: got %0b expected 0", name, color_valid); else passed++;
    prev_top = etop; prev_r = 8'(nr); prev_g = 8'(ng); prev_b = 8'(nb);
  endtask

  task automatic test_frames();
    run_frame("red_wins",    8, 5, 2, 1'b0, 2'd0);
    run_frame("green_tie",   4, 9, 9, 1'b0, 2'd1);
    run_frame("all_tie",     6, 6, 6, 1'b0, 2'd0);
    run_frame("below_min",   2, 1, 0, 1'b0, 2'd3);
    run_frame("settle_only", 0, 0, 0, 1'b1, 2'd3);
  endtask

  task automatic test_abort();
    logic sig [0:40];
    int   vcount;
    for (int i = 0; i <= 40; i++) sig[i] = 1'b0;
    for (int k = 0; k < 7; k++) sig[2 + 2*k]  = 1'b1;
    for (int k = 0; k < 3; k++) sig[27 + 2*k] = 1'b1;
    vcount = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 40; c++) begin
      colorsignal = sig[c];
      if (c == 35) enable = 1'b0;
      @(negedge clk);
      if (color_valid === 1'b1) vcount++;
      if (c == 34) begin
        total++; if ({s2, s3} !== 2'b11) $display("FAIL abort_s2s3_gate: got %b expected 11", {s2, s3}); else passed++;
      end
      if (c == 36) begin
        total++; if ({s2, s3} !== 2'b00) $display("FAIL abort_s2s3_idle: got %b expected 00", {s2, s3}); else passed++;
      end
      @(posedge clk); #1;
    end
    colorsignal = 1'b0;
    total++; if (vcount != 0) $display("FAIL abort_valid: got %0d pulses expected 0", vcount); else passed++;
    total++;
    if ({top_color, red_count, green_count, blue_count} !== {prev_top, prev_r, prev_g, prev_b})
      $display("FAIL abort_outputs: got %0d %0d/%0d/%0d expected %0d %0d/%0d/%0d",
               top_color, red_count, green_count, blue_count, prev_top, prev_r, prev_g, prev_b);
    else passed++;
    run_frame("fresh_after_abort", 1, 7, 3, 1'b0, 2'd1);
  endtask

  task automatic test_mid_reset();
    int vcount;
    vcount = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 90; c++) begin
      colorsignal = (c >= 2 && c <= 10 && (c % 2) == 0);
      if (c == 40) reset = 1'b1;
      if (c == 42) begin reset = 1'b0; enable = 1'b0; end
      @(negedge clk);
      if (color_valid === 1'b1) vcount++;
      if (c == 41) begin
        total++;
        if ({top_color, red_count, green_count, blue_count, s2, s3} !== {2'd3, 24'd0, 2'b00})
          $display("FAIL midreset_state: got top %0d counts %0d/%0d/%0d s2s3 %b expected 3 0/0/0 00",
                   top_color, red_count, green_count, blue_count, {s2, s3});
        else passed++;
      end
      @(posedge clk); #1;
    end
    colorsignal = 1'b0;
    total++; if (vcount != 0) $display("FAIL midreset_valid: got %0d pulses expected 0", vcount); else passed++;
    prev_top = 2'd3; prev_r = 8'd0; prev_g = 8'd0; prev_b = 8'd0;
  endtask

  // Red gate spans cycles 4-67 here; valid lands in cycle 3*(4+64+1)+1 = 208.
  task automatic test_saturation();
    int         vcount, vcycle;
    logic [1:0] got_top;
    logic [3:0] got_r, got_g, got_b;
    vcount = 0; vcycle = -1;
    got_top = 2'd0; got_r = 4'd0; got_g = 4'd0; got_b = 4'd0;
    enable2 = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= 208; c++) begin
      colorsignal2 = (c >= 2 && c < 62 && (c % 2) == 0);
      if (c == 208) enable2 = 1'b0;
      @(negedge clk);
      if (color_valid2 === 1'b1) begin
        vcount++; vcycle = c;
        got_top = top_color2; got_r = red_count2; got_g = green_count2; got_b = blue_count2;
      end
      @(posedge clk); #1;
    end
    colorsignal2 = 1'b0;
    total++; if (vcount != 1 || vcycle != 208)
      $display("FAIL sat_valid: got %0d pulses at cycle %0d expected 1 at 208", vcount, vcycle);
    else passed++;
    total++; if (got_r !== 4'd15) $display("FAIL sat_red: got %0d expected 15", got_r); else passed++;
    total++; if ({got_g, got_b} !== 8'd0) $display("FAIL sat_green_blue: got %0d/%0d expected 0/0", got_g, got_b); else passed++;
    total++; if (got_top !== 2'd0) $display("FAIL sat_top: got %0d expected 0", got_top); else passed++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_abort();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/color_freq_scanner.md
COLOR_FREQ_SCANNER -- requirements
Module: color_freq_scanner

Interface
REQ-001 Parameter GATE_CYCLES, default 100000; clock cycles per edge-counting window (1 ms at 100 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 1000; clock cycles after each filter change before counting starts.
REQ-003 Parameter CNT_W, default 16; width of each channel count.
REQ-004 Parameter MIN_COUNT, default 50; a winning count below this value reports "no color".
REQ-005 The module SHALL use one clock and a synchronous, active-high reset.
REQ-006 clock  in  1  system clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 colorsignal  in  1  sensor frequency output; asynchronous to clock.
REQ-009 enable  in  1  high = run continuous scan frames.
REQ-010 s2  out  1  sensor filter select bit S2.
REQ-011 s3  out  1  sensor filter select bit S3.
REQ-012 top_color  out  2  0 = red, 1 = green, 2 = blue, 3 = none.
REQ-013 color_valid  out  1  one-cycle pulse when top_color and the count outputs update.
REQ-014 red_count, green_count, blue_count  out  CNT_W each  latched counts from the last completed frame.

Function
REQ-015 colorsignal SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected from the synchronized signal as a one-cycle pulse.
REQ-016 Filter encoding {s2,s3}: red = 00, green = 11, blue = 01. Encoding 10 (clear) SHALL never be driven.
REQ-017 The FSM states SHALL be IDLE, SETTLE, GATE, STORE and COMPARE, with a channel index of 0 = red, 1 = green, 2 = blue.
REQ-018 IDLE: the channel is red. If enable=1, go to SETTLE and clear the settle counter.
REQ-019 SETTLE: lasts exactly SETTLE_CYCLES cycles. Edge pulses are ignored. Then go to GATE and clear the edge counter.
REQ-020 GATE: lasts exactly GATE_CYCLES cycles. The edge counter increments on each edge pulse, including one in the final GATE cycle.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 STORE (1 cycle): latch the edge counter into the internal register of the current channel. If the channel is red or green, advance the channel, update s2/s3 in the same cycle, and go to SETTLE. If the channel is blue, go to COMPARE.
REQ-023 COMPARE (1 cycle) selects the channel with the maximum count.
REQ-024 Ties SHALL resolve by priority red > green > blue.
REQ-025 If the maximum count is < MIN_COUNT, top_color SHALL be 3.
REQ-026 On the cycle after COMPARE: top_color and the three count outputs update together, and color_valid=1 for exactly that cycle.
REQ-027 After COMPARE: the channel resets to red; go to SETTLE if enable=1, else IDLE.
REQ-028 Frame period SHALL be 3*(SETTLE_CYCLES+GATE_CYCLES+1)+1 cycles from SETTLE entry to COMPARE exit.
REQ-029 If enable falls in any state other than IDLE, the FSM SHALL go to IDLE on the next cycle and discard the partial frame. Outputs keep their last frame values, no color_valid is issued, and s2/s3 = 00.
REQ-030 s2/s3 SHALL be registered and change only on entry to SETTLE, never during GATE.
REQ-031 Count outputs SHALL NOT change except on the color_valid cycle or at reset.

Reset
REQ-032 While reset=1: state = IDLE, channel = red, s2=0, s3=0, top_color=3, color_valid=0, all counts and counters = 0, and synchronizer flops = 0.
REQ-033 Reset SHALL take priority over enable. Reset mid-frame SHALL abort the frame with no color_valid issued.
REQ-034 Exactly one cycle after reset falls with enable=1, the FSM SHALL enter SETTLE.

Verification (GATE_CYCLES=20, SETTLE_CYCLES=4, CNT_W=8, MIN_COUNT=3)
REQ-035 Edges during GATE: red 8, green 5, blue 2 -> top_color=0; counts 8/5/2; one color_valid pulse 76 cycles after SETTLE entry.
REQ-036 Edges: red 4, green 9, blue 9 -> top_color=1 (tie green over blue). Edges: red 6, green 6, blue 6 -> top_color=0.
REQ-037 Edges: red 2, green 1, blue 0 -> top_color=3; counts 2/1/0 still reported.
REQ-038 colorsignal toggling every cycle during SETTLE only, no edges in GATE -> all counts 0 and top_color=3.
REQ-039 With CNT_W=4 and 30 edges in the red GATE window -> red_count=15 (saturated, no wrap).
REQ-040 enable dropped during the green GATE window -> IDLE next cycle, s2/s3=00, no color_valid, previous outputs unchanged. Re-assert enable -> a full fresh frame starting from red.
